// File: rtl/rom_rr_arbiter.sv
// Round-robin sharing of one registered-read ROM between two requesters; 1 access per 3 cycles.
// Request sampled in N -> gnt at N+1 -> rvalid/rdata at N+3; requests during an access are ignored.
module rom_rr_arbiter #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          busy,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner;
    logic          owner_nxt;
    logic          last;
    logic          last_nxt;
    logic          win1;
    logic          gnt0_nxt;
    logic          gnt1_nxt;
    logic          rvalid0_nxt;
    logic          rvalid1_nxt;
    logic          busy_nxt;
    logic          rom_en_nxt;
    logic [AW-1:0] rom_addr_nxt;
    logic [DW-1:0] rdata_nxt;

    // On a tie the requester that did not win last time goes first.
    assign win1 = req1 & (~req0 | ~last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            busy     <= 1'b0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            rdata    <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            gnt0     <= gnt0_nxt;
            gnt1     <= gnt1_nxt;
            rvalid0  <= rvalid0_nxt;
            rvalid1  <= rvalid1_nxt;
            busy     <= busy_nxt;
            rom_en   <= rom_en_nxt;
            rom_addr <= rom_addr_nxt;
            rdata    <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last;
        gnt0_nxt     = 1'b0;
        gnt1_nxt     = 1'b0;
        rvalid0_nxt  = 1'b0;
        rvalid1_nxt  = 1'b0;
        busy_nxt     = busy;
        rom_en_nxt   = 1'b0;
        rom_addr_nxt = rom_addr;
        rdata_nxt    = rdata;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (req0 | req1) begin
                    state_nxt    = ISSUE;
                    owner_nxt    = win1;
                    last_nxt     = win1;
                    rom_addr_nxt = win1 ? addr1 : addr0;
                    rom_en_nxt   = 1'b1;
                    gnt0_nxt     = ~win1;
                    gnt1_nxt     = win1;
                    busy_nxt     = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = CAPTURE;
                busy_nxt  = 1'b1;
            end
            CAPTURE: begin
                // ROM output registered at the end of ISSUE is valid now.
                state_nxt   = IDLE;
                rdata_nxt   = rom_data;
                rvalid0_nxt = ~owner;
                rvalid1_nxt = owner;
                busy_nxt    = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
